alu_exec_ctrl: RTL

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/jac_pkg.sv | 31 +++
 rtl/jac_regfile.sv | 31 +++
 rtl/alu_exec_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/jac_pkg.sv
// jac_pkg: opcodes, status bit positions, defaults and FSM states shared by alu_exec_ctrl
package jac_pkg;
  localparam int DefDataWidth = 8;
  localparam int DefNumStatusBits = 6;
  localparam int Op_NOP = 0;
  localparam int Op_ADD = 1;
  localparam int Op_SUB = 2;
  localparam int Op_AND = 3;
  localparam int Op_OR = 4;
  localparam int Op_XOR = 5;
  localparam int Op_NOT = 6;
  localparam int Op_SHL = 7;
  localparam int Op_SHR = 8;
  localparam int Op_ADDU = 9;
  localparam int Op_CMP = 10;
  localparam int Op_INC = 11;
  localparam int Op_SUBU = 12;
  localparam int St_Carry = 0;
  localparam int St_Underflow = 1;
  localparam int St_Zero = 2;
  localparam int St_Equal = 3;
  localparam int St_Greater = 4;
  localparam int St_Smaller = 5;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
  function automatic logic op_legal(input logic [31:0] op);
    return op <= 32'(Op_SUBU);
  endfunction
  function automatic logic op_writes_rd(input logic [31:0] op);
    return op_legal(op) && op != 32'(Op_NOP) && op != 32'(Op_CMP);
  endfunction
endpackage

// File: rtl/jac_regfile.sv
// jac_regfile: general registers, one sync write port, two operand reads and a debug read
module jac_regfile #(
  parameter int DataWidth = 8,
  parameter int NumRegs = 8,
  localparam int AW = $clog2(NumRegs)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AW-1:0]        raddr1,
  input  logic [AW-1:0]        raddr2,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DataWidth-1:0] rdata1,
  output logic [DataWidth-1:0] rdata2,
  output logic [DataWidth-1:0] dbg_data
);
  logic [DataWidth-1:0] mem_q [NumRegs];
  logic [DataWidth-1:0] mem_d [NumRegs];
  always_comb begin
    for (int i = 0; i < NumRegs; i++) mem_d[i] = (we && waddr == AW'(i)) ? wdata : mem_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
  assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-state IDLE/EXEC/WB sequencer feeding an external combinational ALU
module alu_exec_ctrl
  import jac_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int NumRegs = 8,
  parameter int NumOpCodeBits = 5,
  parameter int NumStatusBits = DefNumStatusBits,
  localparam int AW = $clog2(NumRegs)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [NumOpCodeBits-1:0] instr_opcode,
  input  logic [AW-1:0]            instr_rd,
  input  logic [AW-1:0]            instr_rs1,
  input  logic [AW-1:0]            instr_rs2,
  input  logic [DataWidth-1:0]     instr_imm,
  input  logic                     instr_use_imm,
  input  logic [DataWidth-1:0]     instr_param,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [DataWidth-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] status_q,
  output logic                     done,
  output logic                     err_illegal,
  input  logic [AW-1:0]            dbg_addr,
  output logic [DataWidth-1:0]     dbg_data
);
  state_e state_q, state_d;
  logic [NumOpCodeBits-1:0] op_q, op_d;
  logic [AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DataWidth-1:0] imm_q, imm_d, param_q, param_d, res_q, res_d;
  logic use_imm_q, use_imm_d, err_q, err_d;
  logic [NumStatusBits-1:0] st_q, st_d, status_d;
  logic [DataWidth-1:0] rdata1, rdata2;
  logic exec, wb, accept, we;
  jac_regfile #(.DataWidth(DataWidth), .NumRegs(NumRegs)) u_regs (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(rd_q), .wdata(res_q),
    .raddr1(rs1_q), .raddr2(rs2_q), .dbg_addr(dbg_addr),
    .rdata1(rdata1), .rdata2(rdata2), .dbg_data(dbg_data)
  );
  always_comb begin
    exec = state_q == EXEC;
    wb = state_q == WB;
    instr_ready = state_q == IDLE;
    accept = instr_valid && instr_ready;
    done = wb;
    state_d = accept ? EXEC : exec ? WB : IDLE;
    op_d = accept ? instr_opcode : op_q;
    rd_d = accept ? instr_rd : rd_q;
    rs1_d = accept ? instr_rs1 : rs1_q;
    rs2_d = accept ? instr_rs2 : rs2_q;
    imm_d = accept ? instr_imm : imm_q;
    use_imm_d = accept ? instr_use_imm : use_imm_q;
    param_d = accept ? instr_param : param_q;
    alu_opcode = exec ? op_q : '0;
    alu_operand1 = exec ? rdata1 : '0;
    alu_operand2 = exec ? (use_imm_q ? imm_q : rdata2) : '0;
    alu_param = exec ? param_q : '0;
    res_d = exec ? alu_result : res_q;
    st_d = exec ? alu_status : st_q;
    // illegal opcodes retire as NOP but leave the sticky flag behind
    we = wb && op_writes_rd(32'(op_q));
    status_d = (wb && op_legal(32'(op_q)) && op_q != '0) ? st_q : status_q;
    err_d = err_q || (wb && !op_legal(32'(op_q)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      use_imm_q <= 1'b0;
      param_q <= '0;
      res_q <= '0;
      st_q <= '0;
      status_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
      use_imm_q <= use_imm_d;
      param_q <= param_d;
      res_q <= res_d;
      st_q <= st_d;
      status_q <= status_d;
      err_q <= err_d;
    end
  end
  assign err_illegal = err_q;
endmodule
